// File: rtl/cb_heep_fault_ctrl.sv
// cb_heep_fault_ctrl
// Register-mapped soft-error injection and exit-loop controller for the
// backpack cores. One FSM drives NCHAN injection lines in OFF, LEVEL,
// ONESHOT or PERIODIC mode, with a programmable start delay. Each channel
// also has an exit-loop request/ack handshake with sticky done status and
// a level completion interrupt.
//
// Ports
//   clk_i           clock
//   rst_ni          asynchronous active-low reset
//   reg_req_i       register-bus request (valid, addr, write, wdata, wstrb)
//   reg_rsp_o       register-bus response (ready, rdata, error)
//   force_error_o   per-channel soft-error injection, registered
//   exit_loop_o     per-channel exit-loop request, registered
//   exit_loop_ack_i per-channel exit-loop acknowledge
//   irq_o           completion interrupt, registered level
//
// Register map (word offsets)
//   0x00 CTRL   [NCHAN-1:0] ch_mask, [9:8] mode, [16] arm (W), [17] stop (W)
//   0x04 DELAY  0x08 PERIOD  0x0C EXIT  0x10 STATUS  0x14 IRQ_EN

package cb_heep_fault_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } reg_req_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
        logic        error;
    } reg_rsp_t;
endpackage

module cb_heep_fault_ctrl #(
    parameter int unsigned NCHAN = 3,
    parameter int unsigned CNT_W = 16,
    parameter type reg_req_t = cb_heep_fault_pkg::reg_req_t,
    parameter type reg_rsp_t = cb_heep_fault_pkg::reg_rsp_t
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  reg_req_t         reg_req_i,
    output reg_rsp_t         reg_rsp_o,
    output logic [NCHAN-1:0] force_error_o,
    output logic [NCHAN-1:0] exit_loop_o,
    input  logic [NCHAN-1:0] exit_loop_ack_i,
    output logic             irq_o
);

    localparam logic [31:0] OFF_CTRL   = 32'h00;
    localparam logic [31:0] OFF_DELAY  = 32'h04;
    localparam logic [31:0] OFF_PERIOD = 32'h08;
    localparam logic [31:0] OFF_EXIT   = 32'h0C;
    localparam logic [31:0] OFF_STATUS = 32'h10;
    localparam logic [31:0] OFF_IRQEN  = 32'h14;

    localparam logic [1:0] MODE_OFF      = 2'd0;
    localparam logic [1:0] MODE_LEVEL    = 2'd1;
    localparam logic [1:0] MODE_PERIODIC = 2'd3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_INJECT = 2'd2;
    localparam logic [1:0] ST_WAIT   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ---------------- register state ----------------
    logic [NCHAN-1:0] ch_mask_q;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] delay_q, period_q, cnt_q, cnt_d;
    logic             irq_en_q;
    logic [NCHAN-1:0] exit_q, exit_d, done_q, done_d;
    logic [7:0]       inj_cnt_q;
    logic [1:0]       state_q, state_d;
    logic             arm_q;
    logic [NCHAN-1:0] force_q;
    logic             irq_q;

    // ---------------- bus decode ----------------
    logic [5:0] hit;
    always_comb begin
        hit = '0;
        case (reg_req_i.addr)
            OFF_CTRL:   hit[0] = 1'b1;
            OFF_DELAY:  hit[1] = 1'b1;
            OFF_PERIOD: hit[2] = 1'b1;
            OFF_EXIT:   hit[3] = 1'b1;
            OFF_STATUS: hit[4] = 1'b1;
            OFF_IRQEN:  hit[5] = 1'b1;
            default:    hit = '0;
        endcase
    end

    logic        bus_err, wr_en;
    logic [31:0] wdata;
    assign bus_err = reg_req_i.valid & ~(|hit);
    assign wr_en   = reg_req_i.valid & reg_req_i.write;
    assign wdata   = reg_req_i.wdata;

    logic ctrl_we, delay_we, period_we, exit_we, status_we, irqen_we;
    assign ctrl_we   = wr_en & hit[0];
    assign delay_we  = wr_en & hit[1];
    assign period_we = wr_en & hit[2];
    assign exit_we   = wr_en & hit[3];
    assign status_we = wr_en & hit[4];
    assign irqen_we  = wr_en & hit[5];

    // A CTRL write selecting OFF behaves like stop; stop beats arm.
    logic ctrl_stop, ctrl_arm;
    assign ctrl_stop = ctrl_we & (wdata[17] | (wdata[9:8] == MODE_OFF));
    assign ctrl_arm  = ctrl_we & wdata[16] & ~ctrl_stop;

    // wstrb is deliberately ignored (full-word writes only).
    logic unused_req;
    assign unused_req = ^reg_req_i;

    // ---------------- read mux ----------------
    logic [31:0] rdata_w;
    always_comb begin
        rdata_w = '0;
        if (hit[0]) begin
            rdata_w[NCHAN-1:0] = ch_mask_q;
            rdata_w[9:8]       = mode_q;
        end
        if (hit[1]) rdata_w[CNT_W-1:0] = delay_q;
        if (hit[2]) rdata_w[CNT_W-1:0] = period_q;
        if (hit[3]) rdata_w[NCHAN-1:0] = exit_q;
        if (hit[4]) begin
            rdata_w[NCHAN-1:0] = done_q;
            rdata_w[16]        = (state_q != ST_IDLE);
            rdata_w[31:24]     = inj_cnt_q;
        end
        if (hit[5]) rdata_w[0] = irq_en_q;

        reg_rsp_o       = '0;
        reg_rsp_o.ready = 1'b1;
        reg_rsp_o.error = bus_err;
        reg_rsp_o.rdata = bus_err ? 32'h0 : rdata_w;
    end

    // ---------------- injection FSM ----------------
    // arm is registered first, so the FSM sees it one edge after the write;
    // together with the registered output this gives first injection D+2
    // edges after the arming write.
    logic arm_go, enter_inj;
    assign arm_go = arm_q & ~ctrl_stop & (mode_q != MODE_OFF);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        enter_inj = 1'b0;
        if (ctrl_stop) begin
            state_d = ST_IDLE;
        end else if (arm_go) begin
            if (delay_q == '0) begin
                state_d   = ST_INJECT;
                enter_inj = 1'b1;
            end else begin
                state_d = ST_DELAY;
                cnt_d   = delay_q;
            end
        end else begin
            case (state_q)
                ST_DELAY, ST_WAIT: begin
                    if (cnt_q <= CNT_ONE) begin
                        state_d   = ST_INJECT;
                        enter_inj = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_INJECT: begin
                    case (mode_q)
                        MODE_LEVEL: state_d = ST_INJECT;
                        MODE_PERIODIC: begin
                            // PERIOD of 0 or 1: re-inject every cycle
                            if (period_q <= CNT_ONE) begin
                                enter_inj = 1'b1;
                            end else begin
                                state_d = ST_WAIT;
                                cnt_d   = period_q - CNT_ONE;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
                default: state_d = state_q;
            endcase
        end
    end

    // ---------------- exit handshake ----------------
    logic [NCHAN-1:0] exit_set, done_clr;
    always_comb begin
        exit_set = exit_we   ? wdata[NCHAN-1:0] : '0;
        done_clr = status_we ? wdata[NCHAN-1:0] : '0;
        exit_d   = (exit_q & ~exit_loop_ack_i) | exit_set;
        done_d   = (done_q & ~done_clr) | (exit_q & exit_loop_ack_i);
    end

    // ---------------- sequential ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ch_mask_q <= '0;
            mode_q    <= MODE_OFF;
            delay_q   <= '0;
            period_q  <= '0;
            irq_en_q  <= 1'b0;
            exit_q    <= '0;
            done_q    <= '0;
            inj_cnt_q <= '0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            arm_q     <= 1'b0;
            force_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            if (ctrl_we) begin
                ch_mask_q <= wdata[NCHAN-1:0];
                mode_q    <= wdata[9:8];
            end
            if (delay_we)  delay_q  <= wdata[CNT_W-1:0];
            if (period_we) period_q <= wdata[CNT_W-1:0];
            if (irqen_we)  irq_en_q <= wdata[0];

            arm_q   <= ctrl_arm;
            state_q <= state_d;
            cnt_q   <= cnt_d;

            if (arm_go)
                inj_cnt_q <= enter_inj ? 8'd1 : 8'd0;
            else if (enter_inj && inj_cnt_q != 8'hFF)
                inj_cnt_q <= inj_cnt_q + 8'd1;

            force_q <= (state_q == ST_INJECT) ? ch_mask_q : '0;
            exit_q  <= exit_d;
            done_q  <= done_d;
            irq_q   <= irq_en_q & (|done_q);
        end
    end

    assign force_error_o = force_q;
    assign exit_loop_o   = exit_q;
    assign irq_o         = irq_q;

endmodule

// File: tb/tb_cb_heep_fault_ctrl.sv
// Directed bench for cb_heep_fault_ctrl: injection modes and latency,
// exit handshake, interrupt, bus errors and asynchronous reset.
module tb_cb_heep_fault_ctrl;
    import cb_heep_fault_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    reg_req_t   req;
    reg_rsp_t   rsp;
    logic [2:0] force_e, exit_o, ack;
    logic       irq;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] rdat;
    logic        rerr;

    always #5 clk = ~clk;

    cb_heep_fault_ctrl #(.NCHAN(3), .CNT_W(16)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .reg_req_i      (req),
        .reg_rsp_o      (rsp),
        .force_error_o  (force_e),
        .exit_loop_o    (exit_o),
        .exit_loop_ack_i(ack),
        .irq_o          (irq)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        req.valid = 1'b1; req.write = 1'b1; req.addr = a; req.wdata = d; req.wstrb = 4'hF;
        @(posedge clk);
        #1;
        req.valid = 1'b0; req.write = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic e);
        req.valid = 1'b1; req.write = 1'b0; req.addr = a;
        #1;
        d = rsp.rdata; e = rsp.error;
        req.valid = 1'b0;
    endtask

    task automatic rdchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        rd(a, rdat, rerr);
        chk(tag, rdat, exp);
        chk({tag, ".err"}, 32'(rerr), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req = '0; ack = '0;
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // reset state
        chk("rst.force", 32'(force_e), 32'h0);
        chk("rst.exit",  32'(exit_o),  32'h0);
        chk("rst.irq",   32'(irq),     32'h0);
        chk("rst.ready", 32'(rsp.ready), 32'h1);
        rdchk("rst.status", 32'h10, 32'h0);
        rdchk("rst.ctrl",   32'h00, 32'h0);

        // ONESHOT, mask 101, DELAY 3: pulse at write edge +5
        wr(32'h04, 32'd3);
        wr(32'h00, 32'h0001_0205);              // E0+1
        rdchk("os.ctrl", 32'h00, 32'h0000_0205);
        tick(2);                                // E2+1
        chk("os.e2", 32'(force_e), 32'h0);
        rdchk("os.busy", 32'h10, 32'h0001_0000);
        tick(2);                                // E4+1
        chk("os.e4", 32'(force_e), 32'h0);
        tick(1);                                // E5+1
        chk("os.e5", 32'(force_e), 32'h5);
        rdchk("os.status", 32'h10, 32'h0100_0000);
        tick(1);                                // E6+1
        chk("os.e6", 32'(force_e), 32'h0);

        // PERIODIC, PERIOD 4, DELAY 0: pulses at E2, E6, E10
        wr(32'h08, 32'd4);
        wr(32'h04, 32'd0);
        wr(32'h00, 32'h0001_0303);              // E0+1
        tick(1);
        chk("per.e1", 32'(force_e), 32'h0);
        tick(1);
        chk("per.e2", 32'(force_e), 32'h3);
        tick(1);
        chk("per.e3", 32'(force_e), 32'h0);
        tick(3);
        chk("per.e6", 32'(force_e), 32'h3);
        tick(4);
        chk("per.e10", 32'(force_e), 32'h3);
        rdchk("per.status", 32'h10, 32'h0301_0000);
        wr(32'h00, 32'h0002_0303);              // stop at E11
        chk("per.stop", 32'(force_e), 32'h0);
        tick(3);                                // E14+1: would be a pulse if not stopped
        chk("per.e14", 32'(force_e), 32'h0);
        rdchk("per.idle", 32'h10, 32'h0300_0000);

        // PERIODIC with PERIOD 0: every cycle, then mode OFF
        wr(32'h08, 32'd0);
        wr(32'h00, 32'h0001_0301);              // E0+1
        tick(2);
        chk("p0.e2", 32'(force_e), 32'h1);
        tick(1);
        chk("p0.e3", 32'(force_e), 32'h1);
        tick(1);
        chk("p0.e4", 32'(force_e), 32'h1);
        rdchk("p0.status", 32'h10, 32'h0401_0000);
        wr(32'h00, 32'h0000_0001);              // mode OFF at E5
        tick(1);
        chk("p0.off", 32'(force_e), 32'h0);
        rdchk("p0.idle", 32'h10, 32'h0400_0000);

        // LEVEL: held until mode OFF
        wr(32'h00, 32'h0001_0106);              // E0+1
        tick(2);
        chk("lvl.e2", 32'(force_e), 32'h6);
        tick(3);
        chk("lvl.e5", 32'(force_e), 32'h6);
        rdchk("lvl.status", 32'h10, 32'h0101_0000);
        wr(32'h00, 32'h0000_0006);
        tick(1);
        chk("lvl.off", 32'(force_e), 32'h0);
        rdchk("lvl.idle", 32'h10, 32'h0100_0000);

        // DELAY 1 boundary: pulse at write edge +3
        wr(32'h04, 32'd1);
        wr(32'h00, 32'h0001_0201);              // E0+1
        tick(2);
        chk("d1.e2", 32'(force_e), 32'h0);
        tick(1);
        chk("d1.e3", 32'(force_e), 32'h1);
        tick(1);
        chk("d1.e4", 32'(force_e), 32'h0);

        // exit handshake, ch0 acked at E2, ch1 at E5
        wr(32'h14, 32'h1);
        wr(32'h0C, 32'h3);                      // E0+1
        chk("ex.req", 32'(exit_o), 32'h3);
        rdchk("ex.rd", 32'h0C, 32'h3);
        tick(1);
        ack = 3'b001;
        tick(1);                                // E2+1
        ack = 3'b000;
        chk("ex.ch0", 32'(exit_o), 32'h2);
        chk("ex.irq0", 32'(irq), 32'h0);
        tick(1);
        chk("ex.irq1", 32'(irq), 32'h1);
        tick(1);                                // E4+1
        chk("ex.hold", 32'(exit_o), 32'h2);
        ack = 3'b010;
        tick(1);                                // E5+1
        ack = 3'b000;
        chk("ex.ch1", 32'(exit_o), 32'h0);
        rdchk("ex.done", 32'h10, 32'h0100_0003);
        wr(32'h10, 32'h3);
        tick(1);
        chk("ex.w1c.irq", 32'(irq), 32'h0);
        rdchk("ex.w1c", 32'h10, 32'h0100_0000);
        ack = 3'b111;                           // ack with no request pending
        tick(1);
        ack = 3'b000;
        tick(1);
        rdchk("ex.spur", 32'h10, 32'h0100_0000);
        chk("ex.spur.irq", 32'(irq), 32'h0);

        // bus errors and dropped writes
        rd(32'h18, rdat, rerr);
        chk("bus.18.err", 32'(rerr), 32'h1);
        chk("bus.18.data", rdat, 32'h0);
        rd(32'h02, rdat, rerr);
        chk("bus.02.err", 32'(rerr), 32'h1);
        chk("bus.02.data", rdat, 32'h0);
        wr(32'h05, 32'd7);
        rdchk("bus.drop", 32'h04, 32'h1);

        // same-cycle ack and EXIT re-write
        wr(32'h0C, 32'h4);
        chk("sc.req", 32'(exit_o), 32'h4);
        ack = 3'b100;
        wr(32'h0C, 32'h4);
        ack = 3'b000;
        chk("sc.hold", 32'(exit_o), 32'h4);
        rdchk("sc.done", 32'h10, 32'h0100_0004);
        tick(1);
        chk("sc.irq", 32'(irq), 32'h1);

        // asynchronous reset mid-handshake
        wr(32'h0C, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.exit",  32'(exit_o),  32'h0);
        chk("ar.irq",   32'(irq),     32'h0);
        chk("ar.force", 32'(force_e), 32'h0);
        rdchk("ar.status", 32'h10, 32'h0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        rdchk("ar.status2", 32'h10, 32'h0);
        rdchk("ar.irqen",   32'h14, 32'h0);
        chk("ar.exit2", 32'(exit_o), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
